// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for serial_sub.
interface serial_sub_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );

endinterface

// File: rtl/serial_sub_full_sub.sv
// Single-bit full subtractor: diff = a - b - bin, with borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtract cell, LSB first,
// valid/ready on both operand and result sides.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_sub: WIDTH out of range");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   diff_sr;
  logic [WIDTH-1:0]   diff_next;
  logic               borrow_q;
  logic               cell_d;
  logic               cell_bout;

  full_sub u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_q),
    .diff (cell_d),
    .bout (cell_bout)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 lands at LSB.
  always_comb begin
    diff_next            = diff_sr >> 1;
    diff_next[WIDTH-1]   = cell_d;
  end

  // Handshake outputs decode the state only, so no input-to-output path exists.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_sr;
  assign bus.borrow    = borrow_q;

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            diff_sr  <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          diff_sr  <= diff_next;
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          borrow_q <= cell_bout;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed-vector bench for serial_sub at WIDTH=8 and WIDTH=1.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) bus8 ();
  serial_sub_if #(.WIDTH(1)) bus1 ();

  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int checks   = 0;
  int failures = 0;

  // Accepts one operand pair from IDLE and waits for out_valid; optionally
  // pulses a bogus operand pair mid-computation.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input bit pulse,
                       output int lat, output logic busy_low);
    bus8.a        = av;
    bus8.b        = bv;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat           = 0;
    busy_low      = 1'b1;
    while (!bus8.out_valid && lat < 40) begin
      if (bus8.in_ready) busy_low = 1'b0;
      if (pulse && lat == 3) begin
        bus8.a        = 8'hAA;
        bus8.b        = 8'h55;
        bus8.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      lat++;
    end
    if (bus8.in_ready) busy_low = 1'b0;
  endtask

  task automatic handshake(output logic ir, output logic ov);
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    ir = bus8.in_ready;
    ov = bus8.out_valid;
  endtask

  task automatic test_reset();
    checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 ||
        bus8.diff !== 8'h00 || bus8.borrow !== 1'b0) begin
      failures++;
      $display("FAIL reset8: in_ready=%b out_valid=%b diff=%h borrow=%b, want 1 0 00 0",
               bus8.in_ready, bus8.out_valid, bus8.diff, bus8.borrow);
    end
    checks++;
    if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 ||
        bus1.diff !== 1'b0 || bus1.borrow !== 1'b0) begin
      failures++;
      $display("FAIL reset1: in_ready=%b out_valid=%b diff=%b borrow=%b, want 1 0 0 0",
               bus1.in_ready, bus1.out_valid, bus1.diff, bus1.borrow);
    end
  endtask

  task automatic test_basic();
    logic [7:0] va [5] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80};
    logic [7:0] vb [5] = '{8'h03, 8'h05, 8'hFF, 8'hFF, 8'h01};
    logic [7:0] ed [5] = '{8'h02, 8'hFE, 8'h01, 8'h00, 8'h7F};
    logic       eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int   lat;
    logic busy_low, ir, ov;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], 1'b0, lat, busy_low);
      checks++;
      if (lat !== 8) begin
        failures++;
        $display("FAIL basic_latency[%0d]: got %0d cycles, want 8", i, lat);
      end
      checks++;
      if (busy_low !== 1'b1) begin
        failures++;
        $display("FAIL basic_in_ready_busy[%0d]: in_ready seen high while busy", i);
      end
      checks++;
      if (bus8.diff !== ed[i] || bus8.borrow !== eb[i]) begin
        failures++;
        $display("FAIL basic_result[%0d]: %h-%h got diff=%h borrow=%b, want %h %b",
                 i, va[i], vb[i], bus8.diff, bus8.borrow, ed[i], eb[i]);
      end
      handshake(ir, ov);
      checks++;
      if (ir !== 1'b1 || ov !== 1'b0) begin
        failures++;
        $display("FAIL basic_handshake[%0d]: in_ready=%b out_valid=%b, want 1 0", i, ir, ov);
      end
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    logic busy_low, ir, ov;
    do_op(8'h03, 8'h05, 1'b0, lat, busy_low);
    bus8.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.diff !== 8'hFE || bus8.borrow !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b diff=%h borrow=%b, want 1 fe 1",
                 i, bus8.out_valid, bus8.diff, bus8.borrow);
      end
    end
    handshake(ir, ov);
    checks++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0", ir, ov);
    end
  endtask

  task automatic test_busy_ignore();
    int   lat;
    logic busy_low, ir, ov;
    do_op(8'h05, 8'h03, 1'b1, lat, busy_low);
    checks++;
    if (lat !== 8 || bus8.diff !== 8'h02 || bus8.borrow !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore_result: lat=%0d diff=%h borrow=%b, want 8 02 0",
               lat, bus8.diff, bus8.borrow);
    end
    handshake(ir, ov);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL busy_ignore_no_second[%0d]: out_valid=%b in_ready=%b, want 0 1",
                 i, bus8.out_valid, bus8.in_ready);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int   lat;
    logic busy_low, ir, ov;
    bus8.a        = 8'h05;
    bus8.b        = 8'h03;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 ||
        bus8.diff !== 8'h00 || bus8.borrow !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_shift: out_valid=%b in_ready=%b diff=%h borrow=%b, want 0 1 00 0",
               bus8.out_valid, bus8.in_ready, bus8.diff, bus8.borrow);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(8'h10, 8'h01, 1'b0, lat, busy_low);
    checks++;
    if (lat !== 8 || bus8.diff !== 8'h0F || bus8.borrow !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_op: lat=%0d diff=%h borrow=%b, want 8 0f 0",
               lat, bus8.diff, bus8.borrow);
    end
    handshake(ir, ov);
  endtask

  task automatic test_width1();
    logic ea [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic ed [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic eo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      bus1.a        = ea[i];
      bus1.b        = eb[i];
      bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat !== 1 || bus1.diff !== ed[i] || bus1.borrow !== eo[i]) begin
        failures++;
        $display("FAIL width1[%0d]: a=%b b=%b lat=%0d diff=%b borrow=%b, want 1 %b %b",
                 i, ea[i], eb[i], lat, bus1.diff, bus1.borrow, ed[i], eo[i]);
      end
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_shift();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
